alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
Upstream front-end for the 5-operand fixed-point ALU, which computes ops0*ops1 + ops2*ops3 + ops4, or ops0 + ops2 when f_add=1.
- Accepts a command (MAC or ADD) over a valid/ready handshake.
- Streams operand bytes from a single narrow bus into the ALU's per-operand input registers.
- Waits one cycle for the combinational result to settle, captures it, and presents it on a valid/ready output.
- Removes per-operand load sequencing from the controller.

Parameters:
BUS_WIDTH, 8, width of operand, data and result buses.
CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock, rising edge.
n_reset  input  1  asynchronous active-low reset.
cmd_valid  input  1  command offered.
cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
cmd_op  input  1  0 = MAC (5 operands), 1 = ADD (2 operands).
in_valid  input  1  operand byte offered.
in_ready  output  1  operand byte accepted when high with in_valid.
in_data  input  BUS_WIDTH  operand byte, signed.
alu_ops  output  5 x BUS_WIDTH  packed operand lanes to the ALU ops input.
alu_reg_en  output  5  one-hot operand register enable to the ALU.
alu_f_add  output  1  ALU mode select.
alu_result  input  BUS_WIDTH  combinational ALU result.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
out_data  output  BUS_WIDTH  registered result.
busy  output  1  high in any state other than IDLE.
op_count  output  CNT_WIDTH  number of results consumed.

Behaviour:
- States: IDLE, LOAD, SETTLE, OUT. Reset enters IDLE.
- Reset values: out_data=0, out_valid=0, alu_f_add=0, op_count=0, slot index=0, mode register=0.
- Reset mid-operation aborts immediately; no partial result is ever presented.
- All lanes of alu_ops carry in_data combinationally at all times; operand selection is done solely by alu_reg_en.
- alu_reg_en = one-hot(current slot) when state==LOAD && in_valid; otherwise 0.
- Slot order: MAC loads 0,1,2,3,4. ADD loads 0,2. ALU lanes 1, 3 and 4 are ignored in ADD mode.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: register cmd_op into the mode register and alu_f_add, reset the slot pointer to the first slot, go to LOAD.
- LOAD:
  - in_ready=1, cmd_ready=0.
  - Each in_valid cycle writes one slot and advances the pointer.
  - Accepting the last slot (4 for MAC, 2 for ADD) goes to SETTLE.
  - in_valid low stalls indefinitely with no enables asserted.
- SETTLE:
  - Exactly one cycle; the ALU registers hold all operands.
  - At the end of the cycle, out_data <= alu_result, out_valid <= 1, go to OUT.
- OUT:
  - out_valid=1, out_data stable.
  - On out_ready: op_count increments, wrapping modulo 2^CNT_WIDTH.
  - cmd_ready = out_ready in this state, so a new command can be accepted in the same cycle the result is consumed.
  - If out_ready && cmd_valid: accept the command and go directly to LOAD; out_valid drops next cycle.
  - Else if out_ready: go to IDLE.
  - Else: hold.
- alu_f_add changes only on command acceptance and is stable throughout LOAD, SETTLE and OUT.
- Latency: the result appears on out_data one cycle after the last operand handshake, i.e. a minimum of 7 cycles from command accept for MAC and 4 for ADD.
- in_valid outside LOAD is ignored (in_ready=0). cmd_valid in LOAD or SETTLE is held off (cmd_ready=0).
- No width growth: out_data is alu_result as produced, wrapping 8-bit signed.

Test Plan:
- MAC: cmd_op=0; operands 0x10, 0x40, 0x08, 0x20, 0x03 on consecutive cycles -> alu_reg_en 00001, 00010, 00100, 01000, 10000; out_valid one cycle after the last operand; out_data=0x0D (16*0.5 + 8*0.25 + 3).
- ADD: cmd_op=1; operands 0x05, 0x07 -> alu_reg_en 00001 then 00100; alu_f_add=1; out_data=0x0C; busy falls the cycle after out_ready.
- Stalls: MAC with in_valid low for 3 cycles between operands 2 and 3, and out_ready held low for 5 cycles -> no spurious enables; out_data stable at 0x0D throughout; op_count increments exactly once.
- Back-to-back: in OUT, assert out_ready and cmd_valid (ADD) together -> next state is LOAD with no IDLE cycle; second result 0x0C; op_count=2.
- Reset mid-LOAD after 3 MAC operands -> all outputs at reset values; the following ADD 0x01+0x01 yields 0x02.
- Counter wrap: CNT_WIDTH=2, complete 5 operations -> op_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - command/operand sequencer in front of the 5-operand fixed-point ALU
module alu_operand_sequencer #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BUS_WIDTH-1:0]   in_data,
    output logic [5*BUS_WIDTH-1:0] alu_ops,
    output logic [4:0]             alu_reg_en,
    output logic                   alu_f_add,
    input  logic [BUS_WIDTH-1:0]   alu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BUS_WIDTH-1:0]   out_data,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   op_count
);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, OUT} state_t;

    state_t     state, state_next;
    logic [2:0] slot, slot_next;
    logic       mode;
    logic       cmd_take, in_take, last_slot;

    // Every lane sees the bus; the one-hot enable picks which ALU register loads.
    assign alu_ops    = {5{in_data}};
    assign cmd_take   = cmd_ready && cmd_valid;
    assign in_take    = in_ready && in_valid;
    assign last_slot  = mode ? (slot == 3'd2) : (slot == 3'd4);
    assign slot_next  = (mode && slot == 3'd0) ? 3'd2 : slot + 3'd1;
    assign alu_reg_en = in_take ? (5'd1 << slot) : 5'd0;
    assign out_valid  = (state == OUT);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_slot) state_next = SETTLE;
            end
            SETTLE: state_next = OUT;
            OUT: begin
                // Consuming the result frees the command port in the same cycle.
                cmd_ready = out_ready;
                if (out_ready) state_next = cmd_valid ? LOAD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            slot      <= 3'd0;
            mode      <= 1'b0;
            alu_f_add <= 1'b0;
            out_data  <= '0;
            op_count  <= '0;
        end else begin
            state <= state_next;
            if (cmd_take) begin
                mode      <= cmd_op;
                alu_f_add <= cmd_op;
                slot      <= 3'd0;
            end else if (in_take) begin
                slot <= slot_next;
            end
            if (state == SETTLE) out_data <= alu_result;
            if (out_valid && out_ready) op_count <= op_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - scoreboard bench for alu_operand_sequencer with a Q1.7 ALU model
module tb_alu_operand_sequencer;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cmd_valid, cmd_op, in_valid, out_ready;
    logic [7:0]  in_data;
    logic        cmd_ready, in_ready, alu_f_add, out_valid, busy;
    logic [39:0] alu_ops;
    logic [4:0]  alu_reg_en;
    logic [7:0]  alu_result, out_data;
    logic [15:0] op_count;

    logic        s_cmd_ready, s_in_ready, s_alu_f_add, s_out_valid, s_busy;
    logic [39:0] s_alu_ops;
    logic [4:0]  s_alu_reg_en;
    logic [7:0]  s_out_data;
    logic [1:0]  s_op_count;

    typedef struct packed {
        logic [7:0] data;
        logic       f_add;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.BUS_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .alu_ops(alu_ops), .alu_reg_en(alu_reg_en), .alu_f_add(alu_f_add),
        .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .op_count(op_count)
    );

    alu_operand_sequencer #(.BUS_WIDTH(8), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_op(cmd_op), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .alu_ops(s_alu_ops), .alu_reg_en(s_alu_reg_en), .alu_f_add(s_alu_f_add),
        .alu_result(alu_result), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .busy(s_busy), .op_count(s_op_count)
    );

    // Behavioural ALU: per-lane enabled registers, Q1.7 products, combinational result.
    logic signed [7:0]  r0, r1, r2, r3, r4;
    logic signed [15:0] p0, p1;
    always @(posedge clk) begin
        if (alu_reg_en[0]) r0 <= alu_ops[7:0];
        if (alu_reg_en[1]) r1 <= alu_ops[15:8];
        if (alu_reg_en[2]) r2 <= alu_ops[23:16];
        if (alu_reg_en[3]) r3 <= alu_ops[31:24];
        if (alu_reg_en[4]) r4 <= alu_ops[39:32];
    end
    always_comb begin
        p0 = r0 * r1;
        p1 = r2 * r3;
        alu_result = alu_f_add ? 8'(r0 + r2)
                               : 8'(8'(p0 >>> 7) + 8'(p1 >>> 7) + r4);
    end

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected: got result %0h with no expected entry", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", {32'd0, out_data}, {32'd0, e.data});
                chk("alu_f_add", {39'd0, alu_f_add}, {39'd0, e.f_add});
                chk("small_out_data", {32'd0, s_out_data}, {32'd0, e.data});
            end
        end
    end

    task automatic send_cmd(input logic op, input logic push, input logic [7:0] exp_data);
        bit ok = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("cmd_timeout", 40'd0, 40'd1);
        if (push) sb.push_back('{data: exp_data, f_add: op});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] d, input logic [4:0] exp_en);
        logic [39:0] exp_ops;
        exp_ops  = {5{d}};
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        chk("in_ready", {39'd0, in_ready}, 40'd1);
        chk("alu_reg_en", {35'd0, alu_reg_en}, {35'd0, exp_en});
        chk("alu_ops", alu_ops, exp_ops);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("out_valid_timeout", 40'd0, 40'd1);
        @(posedge clk); #1;
    endtask

    task automatic consume();
        bit ok = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("consume_timeout", 40'd0, 40'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic mac_ops();
        send_op(8'h10, 5'b00001);
        send_op(8'h40, 5'b00010);
        send_op(8'h08, 5'b00100);
        send_op(8'h20, 5'b01000);
        send_op(8'h03, 5'b10000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] wrap_exp [5];
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        n_reset = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {39'd0, out_valid}, 40'd0);
        chk("rst_out_data", {32'd0, out_data}, 40'd0);
        chk("rst_f_add", {39'd0, alu_f_add}, 40'd0);
        chk("rst_op_count", {24'd0, op_count}, 40'd0);
        chk("rst_busy", {39'd0, busy}, 40'd0);
        chk("rst_cmd_ready", {39'd0, cmd_ready}, 40'd1);
        chk("rst_in_ready", {39'd0, in_ready}, 40'd0);
        @(posedge clk); #1;
        n_reset = 1'b1;

        // MAC with latency check: SETTLE cycle shows no result, next cycle does.
        send_cmd(1'b0, 1'b1, 8'h0D);
        mac_ops();
        @(negedge clk);
        chk("settle_out_valid", {39'd0, out_valid}, 40'd0);
        chk("settle_busy", {39'd0, busy}, 40'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("latency_out_valid", {39'd0, out_valid}, 40'd1);
        @(posedge clk); #1;
        consume();
        chk("mac_op_count", {24'd0, op_count}, 40'd1);

        // ADD
        send_cmd(1'b1, 1'b1, 8'h0C);
        chk("add_f_add", {39'd0, alu_f_add}, 40'd1);
        send_op(8'h05, 5'b00001);
        send_op(8'h07, 5'b00100);
        consume();
        @(negedge clk);
        chk("add_busy_fall", {39'd0, busy}, 40'd0);
        chk("add_op_count", {24'd0, op_count}, 40'd2);
        @(posedge clk); #1;

        // Operand stall and output back-pressure
        send_cmd(1'b0, 1'b1, 8'h0D);
        send_op(8'h10, 5'b00001);
        send_op(8'h40, 5'b00010);
        send_op(8'h08, 5'b00100);
        in_valid = 1'b1;
        #1 in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_reg_en", {35'd0, alu_reg_en}, 40'd0);
            chk("stall_busy", {39'd0, busy}, 40'd1);
            @(posedge clk); #1;
        end
        send_op(8'h20, 5'b01000);
        send_op(8'h03, 5'b10000);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            chk("hold_out_data", {32'd0, out_data}, 40'h0D);
            chk("hold_out_valid", {39'd0, out_valid}, 40'd1);
            chk("hold_op_count", {24'd0, op_count}, 40'd2);
            @(posedge clk); #1;
        end
        consume();
        chk("stall_op_count", {24'd0, op_count}, 40'd3);

        // Back-to-back: consume and accept the next command in one cycle
        send_cmd(1'b0, 1'b1, 8'h0D);
        mac_ops();
        wait_valid();
        out_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b1;
        sb.push_back('{data: 8'h0C, f_add: 1'b1});
        @(negedge clk);
        chk("b2b_cmd_ready", {39'd0, cmd_ready}, 40'd1);
        @(posedge clk); #1;
        out_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_out_valid", {39'd0, out_valid}, 40'd0);
        chk("b2b_in_ready", {39'd0, in_ready}, 40'd1);
        chk("b2b_busy", {39'd0, busy}, 40'd1);
        chk("b2b_op_count1", {24'd0, op_count}, 40'd4);
        @(posedge clk); #1;
        send_op(8'h05, 5'b00001);
        send_op(8'h07, 5'b00100);
        consume();
        chk("b2b_op_count2", {24'd0, op_count}, 40'd5);

        // Reset partway through a MAC load
        send_cmd(1'b0, 1'b0, 8'h00);
        send_op(8'h10, 5'b00001);
        send_op(8'h40, 5'b00010);
        send_op(8'h08, 5'b00100);
        n_reset = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        #2;
        chk("mid_rst_out_data", {32'd0, out_data}, 40'd0);
        chk("mid_rst_out_valid", {39'd0, out_valid}, 40'd0);
        chk("mid_rst_busy", {39'd0, busy}, 40'd0);
        chk("mid_rst_op_count", {24'd0, op_count}, 40'd0);
        chk("mid_rst_reg_en", {35'd0, alu_reg_en}, 40'd0);
        chk("mid_rst_in_ready", {39'd0, in_ready}, 40'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_reset = 1'b1;

        // Five completions after reset, with signed wrap cases; CNT_WIDTH=2 copy wraps
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin send_cmd(1'b1, 1'b1, 8'h02); send_op(8'h01, 5'b00001); send_op(8'h01, 5'b00100); end
                1: begin send_cmd(1'b1, 1'b1, 8'h80); send_op(8'h7F, 5'b00001); send_op(8'h01, 5'b00100); end
                2: begin send_cmd(1'b1, 1'b1, 8'h00); send_op(8'h80, 5'b00001); send_op(8'h80, 5'b00100); end
                3: begin
                    send_cmd(1'b0, 1'b1, 8'hE5);
                    send_op(8'hC0, 5'b00001); send_op(8'h40, 5'b00010); send_op(8'h00, 5'b00100);
                    send_op(8'h00, 5'b01000); send_op(8'h05, 5'b10000);
                end
                default: begin send_cmd(1'b1, 1'b1, 8'hFE); send_op(8'hFD, 5'b00001); send_op(8'h01, 5'b00100); end
            endcase
            consume();
            chk("wrap_small_count", {38'd0, s_op_count}, {38'd0, wrap_exp[k]});
            chk("wrap_big_count", {24'd0, op_count}, 40'(k + 1));
        end

        chk("sb_drained", 40'(sb.size()), 40'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
